// File: rtl/gate_tt_pkg.sv
// Shared types and reference truth tables for the 2-input gate checker.
// Truth-table bit index is {a,b}.
package gate_tt_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample,
        StDone
    } state_e;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_tt_checker_timer.sv
// Settle timer: 4-bit counter that is cleared by load_i and flags the last settle cycle.
module tt_settle_timer #(
    parameter int unsigned SettleCycles = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [3:0] LastCount = 4'(SettleCycles - 1);

    logic [3:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = (count_q == LastCount);

endmodule

// File: rtl/gate_tt_checker.sv
// Truth-table checker: walks {a,b} through 00..11, waits SETTLE_CYCLES per vector,
// then samples gate_out once and records mismatches against EXP_TT.
module gate_tt_checker
    import gate_tt_pkg::*;
#(
    parameter logic [3:0]  EXP_TT        = TT_OR,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       gate_out,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [1:0] vec_idx
);

    state_e     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [3:0] mask_q, mask_d, mask_upd;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic       tmr_load, tmr_en, tmr_expire;

    tt_settle_timer #(
        .SettleCycles(SETTLE_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (tmr_load),
        .en_i    (tmr_en),
        .expire_o(tmr_expire)
    );

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        mask_d   = mask_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        mask_upd = mask_q;
        if (gate_out != EXP_TT[vec_q]) begin
            mask_upd[vec_q] = 1'b1;
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d  = StSettle;
                    vec_d    = 2'd0;
                    mask_d   = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    tmr_load = 1'b1;
                end
            end
            StSettle: begin
                tmr_en = 1'b1;
                if (tmr_expire) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                mask_d = mask_upd;
                if (vec_q == 2'd3) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    // Pass must include the compare made on this very edge.
                    pass_d  = (mask_upd == 4'd0);
                end else begin
                    state_d  = StSettle;
                    vec_d    = vec_q + 2'd1;
                    tmr_load = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            vec_q   <= '0;
            mask_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            mask_q  <= mask_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign a         = vec_q[1];
    assign b         = vec_q[0];
    assign vec_idx   = vec_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_mask = mask_q;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Bench for gate_tt_checker: three instances (OR/S=2, XOR/S=2, NAND/S=1) checked every cycle
// against a schedule-based model, plus directed scenarios with literal expectations.
module tb_gate_tt_checker;

    logic clk;
    logic rst;
    logic [2:0] start_r;
    logic [2:0] gout;
    logic [2:0] a_w, b_w, busy_w, done_w, pass_w;
    logic [3:0] fm_w [3];
    logic [1:0] vi_w [3];

    int mode [3];        // 0 real gate, 1 AND, 2 const 1, 3 glitch in settle, 4 random
    logic [2:0] gw;      // glitch: drive wrong value this cycle
    logic [2:0] rb;      // random gate_out bit for this cycle

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Model state, per instance
    int         s_of  [3] = '{2, 2, 1};
    logic [3:0] tt_of [3] = '{4'b1110, 4'b0110, 4'b0111};
    bit         run_m [3];
    int         e_m   [3];
    logic [3:0] mask_m[3];
    bit         done_m[3];
    bit         pass_m[3];

    gate_tt_checker #(.EXP_TT(4'b1110), .SETTLE_CYCLES(2)) u_or (
        .clk(clk), .rst(rst), .start(start_r[0]), .gate_out(gout[0]),
        .a(a_w[0]), .b(b_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .fail_mask(fm_w[0]), .vec_idx(vi_w[0])
    );
    gate_tt_checker #(.EXP_TT(4'b0110), .SETTLE_CYCLES(2)) u_xor (
        .clk(clk), .rst(rst), .start(start_r[1]), .gate_out(gout[1]),
        .a(a_w[1]), .b(b_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .fail_mask(fm_w[1]), .vec_idx(vi_w[1])
    );
    gate_tt_checker #(.EXP_TT(4'b0111), .SETTLE_CYCLES(1)) u_nand (
        .clk(clk), .rst(rst), .start(start_r[2]), .gate_out(gout[2]),
        .a(a_w[2]), .b(b_w[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
        .fail_mask(fm_w[2]), .vec_idx(vi_w[2])
    );

    function automatic logic gate_fn(input int i, input int md, input logic x, input logic y,
                                     input logic wrong, input logic rnd);
        logic g;
        case (i)
            0:       g = x | y;
            1:       g = x ^ y;
            default: g = ~(x & y);
        endcase
        case (md)
            0:       return g;
            1:       return x & y;
            2:       return 1'b1;
            3:       return wrong ? ~g : g;
            default: return rnd;
        endcase
    endfunction

    assign gout[0] = gate_fn(0, mode[0], a_w[0], b_w[0], gw[0], rb[0]);
    assign gout[1] = gate_fn(1, mode[1], a_w[1], b_w[1], gw[1], rb[1]);
    assign gout[2] = gate_fn(2, mode[2], a_w[2], b_w[2], gw[2], rb[2]);

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: after acceptance, cycle e is in vector e/(S+1); the cycle with offset S samples.
    task automatic model_step(input int i);
        int s1, v;
        s1 = s_of[i] + 1;
        if (rst) begin
            run_m[i] = 0; e_m[i] = 0; mask_m[i] = 4'd0; done_m[i] = 0; pass_m[i] = 0;
        end else if (run_m[i]) begin
            if (e_m[i] % s1 == s_of[i]) begin
                v = e_m[i] / s1;
                if (gout[i] != tt_of[i][v]) mask_m[i][v] = 1'b1;
                if (v == 3) begin
                    run_m[i] = 0;
                    done_m[i] = 1;
                    pass_m[i] = (mask_m[i] == 4'd0);
                end
            end
            e_m[i]++;
        end else if (start_r[i]) begin
            run_m[i] = 1; e_m[i] = 0; mask_m[i] = 4'd0; done_m[i] = 0; pass_m[i] = 0;
        end
    endtask

    task automatic model_cmp(input int i);
        int s1, v;
        s1 = s_of[i] + 1;
        v = run_m[i] ? e_m[i] / s1 : (done_m[i] ? 3 : 0);
        chk($sformatf("u%0d busy", i), int'(busy_w[i]), int'(run_m[i]));
        chk($sformatf("u%0d done", i), int'(done_w[i]), int'(done_m[i]));
        chk($sformatf("u%0d pass", i), int'(pass_w[i]), int'(pass_m[i]));
        chk($sformatf("u%0d fail_mask", i), int'(fm_w[i]), int'(mask_m[i]));
        chk($sformatf("u%0d vec_idx", i), int'(vi_w[i]), v);
        chk($sformatf("u%0d ab", i), int'({a_w[i], b_w[i]}), v);
        gw[i] = !(run_m[i] && (e_m[i] % s1 == s_of[i]));
        rb[i] = 1'($urandom_range(1, 0));
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            run_m[i] = 0; e_m[i] = 0; mask_m[i] = 4'd0; done_m[i] = 0; pass_m[i] = 0;
        end
        gw = 3'b000;
        rb = 3'b000;
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) model_step(i);
            @(negedge clk);
            for (int i = 0; i < 3; i++) model_cmp(i);
        end
    end

    // Returns at the negedge right after the edge that accepts start.
    task automatic pulse(input int i);
        @(negedge clk);
        start_r[i] = 1'b1;
        @(negedge clk);
        start_r[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, output int t);
        t = -1;
        for (int k = 0; k < 60; k++) begin
            if (done_w[i]) begin
                t = cyc;
                break;
            end
            @(negedge clk);
        end
        if (t < 0) chk($sformatf("u%0d done timeout", i), 0, 1);
    endtask

    task automatic wait_vec(input int i, input int v);
        bit ok;
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            if (int'(vi_w[i]) == v) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk($sformatf("u%0d vec wait", i), 0, 1);
    endtask

    initial begin
        int t0, t1;
        int exp_ab [12] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
        rst = 1'b1;
        start_r = 3'b000;
        for (int i = 0; i < 3; i++) mode[i] = 0;
        repeat (2) @(negedge clk);
        chk("reset busy", int'(busy_w[0]), 0);
        chk("reset fail_mask", int'(fm_w[0]), 0);
        rst = 1'b0;

        // OR with real OR gate: a/b sequence, 13-edge latency counting the accept edge
        pulse(0);
        t0 = cyc;
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("or ab seq %0d", k), int'({a_w[0], b_w[0]}), exp_ab[k]);
            @(negedge clk);
        end
        wait_done(0, t1);
        chk("or latency", t1 - t0 + 1, 13);
        chk("or pass", int'(pass_w[0]), 1);
        chk("or mask", int'(fm_w[0]), 4'b0000);

        // OR expected, AND gate fitted
        mode[0] = 1;
        pulse(0);
        wait_done(0, t1);
        chk("and-as-or mask", int'(fm_w[0]), 4'b0110);
        chk("and-as-or pass", int'(pass_w[0]), 0);

        // XOR expected, output stuck at 1; then restart from DONE with a real XOR
        mode[1] = 2;
        pulse(1);
        wait_done(1, t1);
        chk("xor stuck mask", int'(fm_w[1]), 4'b1001);
        chk("xor stuck pass", int'(pass_w[1]), 0);
        mode[1] = 0;
        pulse(1);
        chk("xor restart mask", int'(fm_w[1]), 0);
        chk("xor restart done", int'(done_w[1]), 0);
        chk("xor restart pass", int'(pass_w[1]), 0);
        chk("xor restart busy", int'(busy_w[1]), 1);
        wait_done(1, t1);
        chk("xor pass", int'(pass_w[1]), 1);

        // NAND with one settle cycle; a second start mid-check is ignored
        pulse(2);
        t0 = cyc;
        wait_vec(2, 2);
        start_r[2] = 1'b1;
        @(negedge clk);
        start_r[2] = 1'b0;
        wait_done(2, t1);
        chk("nand latency", t1 - t0 + 1, 9);
        chk("nand pass", int'(pass_w[2]), 1);
        chk("nand mask", int'(fm_w[2]), 0);

        // Asynchronous reset in the settle phase of vector 1
        mode[0] = 0;
        pulse(0);
        wait_vec(0, 1);
        #2 rst = 1'b1;
        #1;
        chk("async rst busy", int'(busy_w[0]), 0);
        chk("async rst a", int'(a_w[0]), 0);
        chk("async rst b", int'(b_w[0]), 0);
        chk("async rst mask", int'(fm_w[0]), 0);
        chk("async rst vec", int'(vi_w[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        pulse(0);
        wait_done(0, t1);
        chk("post rst pass", int'(pass_w[0]), 1);

        // gate_out wrong only while settling
        mode[0] = 3;
        pulse(0);
        wait_done(0, t1);
        chk("glitch pass", int'(pass_w[0]), 1);
        chk("glitch mask", int'(fm_w[0]), 0);

        // Random gate output and random start requests on all instances
        for (int i = 0; i < 3; i++) mode[i] = 4;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) start_r[i] = ($urandom_range(3, 0) == 0);
        end
        @(negedge clk);
        start_r = 3'b000;
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gate_tt_checker.md
Name: gate_tt_checker

Overview:
- Hardware truth-table checker for any 2-input logic gate in the lab library (OR, AND, XOR, NAND, ...).
- Sequencer drives the gate's inputs a/b through all four combinations and waits a settle interval. It then samples the gate's output and compares it against a parameterised expected truth table.
- Sits on the opposite side of the gate interface from the gate itself: drives a/b and receives the gate output. Replaces hand-written per-gate stimulus with a synthesizable self-check.

Parameters:
- EXP_TT, 4'b1110, expected output per vector; bit index = {a,b}. Default is OR.
- SETTLE_CYCLES, 2, cycles the gate inputs are held before sampling. Legal range 1..15.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a full 4-vector check; accepted only in IDLE or DONE.
- gate_out  input  1  output of the gate under check.
- a  output  1  gate input a (vector index bit 1).
- b  output  1  gate input b (vector index bit 0).
- busy  output  1  high from start acceptance until DONE is entered.
- done  output  1  high while in DONE; held until the next accepted start.
- pass  output  1  valid when done=1; equals (fail_mask == 0).
- fail_mask  output  4  bit i set if vector i mismatched; cleared on start acceptance.
- vec_idx  output  2  index of the vector currently applied.

Behaviour:
- Reset (async, immediate): state=IDLE; a=0, b=0, busy=0, done=0, pass=0, fail_mask=0, vec_idx=0, settle count=0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, start=1: next edge enters SETTLE with vec_idx=0, {a,b}=00, count=0, busy=1, fail_mask=0. start=0: stay.
- SETTLE: count increments each cycle. When count==SETTLE_CYCLES-1, next state is SAMPLE. a/b are held stable.
- SAMPLE, one cycle: if gate_out != EXP_TT[vec_idx], set fail_mask[vec_idx].
  - If vec_idx==3: go to DONE, busy=0, done=1. pass is registered from the final mask, including this cycle's compare.
  - Otherwise: vec_idx+1, {a,b}=vec_idx+1, count=0, next state SETTLE.
- DONE: a/b hold 11; done and pass hold. start=1 restarts exactly as from IDLE: done=0, pass=0 and fail_mask=0 on the same edge.
- start while busy: ignored; no restart, no effect on results.
- Latency: done rises 1 + 4*(SETTLE_CYCLES+1) cycles after the edge that samples start. SETTLE_CYCLES=2 gives 13 cycles.
- gate_out is sampled only in SAMPLE; its value in other states is don't-care.
- Reset mid-check: abort immediately to IDLE with all outputs cleared; results are lost.
- vec_idx wraps only via restart; never increments past 3.
- Counter width: 4 bits; compare uses SETTLE_CYCLES-1, so SETTLE_CYCLES=1 gives one SETTLE cycle.

Decomposition:
- Shared package gate_tt_pkg:
  - State enum (IDLE, SETTLE, SAMPLE, DONE).
  - Truth-table constants: TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_NAND=4'b0111, TT_NOR=4'b0001, TT_XNOR=4'b1001.
- One natural sub-module, tt_settle_timer: 4-bit load/count with an expire flag at SETTLE_CYCLES-1. The FSM, vector register and result registers stay in the top level.

Test Plan:
- EXP_TT=TT_OR, gate_out driven by a real OR of a/b, pulse start -> done after 13 cycles, pass=1, fail_mask=0000. Check a/b sequence 00,01,10,11, each held 3 cycles.
- EXP_TT=TT_OR, gate_out driven by AND of a/b -> pass=0, fail_mask=0110.
- EXP_TT=TT_XOR, gate_out tied to 1 -> fail_mask=1001, pass=0. Then pulse start in DONE with a correct XOR -> fail_mask clears on the accept edge, final pass=1.
- SETTLE_CYCLES=1, correct NAND -> done 9 cycles after start. Second start pulse at vector 2 is ignored: no restart, same done timing.
- Assert rst asynchronously mid-SETTLE of vector 1 -> busy, a, b, fail_mask, vec_idx go to 0 without waiting for a clock edge. A later start runs a clean full check with pass=1.
- Glitch gate_out to the wrong value during SETTLE only, correct in SAMPLE -> pass=1, fail_mask=0000.
